// File: rtl/tlv_i2c_arb_pkg.sv
// Shared types and widths for the TLV493 I2C master arbiter.
package tlv_i2c_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      RUN,
      GAP
   } arb_state_e;

   localparam int I2C_ADDR_W = 7;
   localparam int NBYTES_W   = 8;
   localparam int DATA_W     = 32;

   localparam logic [I2C_ADDR_W-1:0] TLV_I2C_ADDR = 7'h5e;

   // Index width that stays legal for a single requester.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tlv_i2c_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o
);

   always_comb begin
      logic             found;
      logic [IDX_W-1:0] cand;
      found   = 1'b0;
      cand    = '0;
      grant_o = '0;
      idx_o   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            idx_o         = cand;
            grant_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tlv_i2c_arbiter.sv
// Shares one i2c_master between NUM_REQ requesters, one whole transaction per grant,
// round-robin, with a start timeout and an enforced bus-free gap between transactions.
module tlv_i2c_arbiter
   import tlv_i2c_arb_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int CLOCK_SPEED_HZ  = 50_000_000,
   parameter int START_TIMEOUT   = 1000,
   parameter int BUS_FREE_CYCLES = CLOCK_SPEED_HZ / 400_000
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [7*NUM_REQ-1:0]       req_addr,
   input  logic [NUM_REQ-1:0]         req_rw,
   input  logic [NUM_REQ-1:0]         req_read_only,
   input  logic [8*NUM_REQ-1:0]       req_nbytes,
   input  logic [32*NUM_REQ-1:0]      req_data_wr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_REQ-1:0]         done,
   output logic [NUM_REQ-1:0]         err,
   output logic [NUM_REQ-1:0]         timeout,
   output logic [31:0]                rd_data,
   output logic [NUM_REQ-1:0]         rd_valid,
   output logic                       m_ena,
   output logic [6:0]                 m_addr,
   output logic                       m_rw,
   output logic                       m_read_only,
   output logic [7:0]                 m_nbytes,
   output logic [31:0]                m_data_wr,
   input  logic                       m_busy,
   input  logic                       m_ack_error,
   input  logic [7:0]                 m_byte_counter,
   input  logic [31:0]                m_data_rd,
   input  logic                       m_fifo_write_ack
);

   localparam int IDX_W   = idx_width(NUM_REQ);
   localparam int TMR_MAX = (START_TIMEOUT > BUS_FREE_CYCLES) ? START_TIMEOUT : BUS_FREE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(START_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(BUS_FREE_CYCLES - 1);

   arb_state_e              state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [TMR_W-1:0]        timer_q, timer_d;
   logic [NUM_REQ-1:0]      done_q, done_d;
   logic [NUM_REQ-1:0]      err_q, err_d;
   logic [NUM_REQ-1:0]      timeout_q, timeout_d;
   logic                    m_ena_q, m_ena_d;
   logic [I2C_ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic                    m_rw_q, m_rw_d;
   logic                    m_read_only_q, m_read_only_d;
   logic [NBYTES_W-1:0]     m_nbytes_q, m_nbytes_d;
   logic [DATA_W-1:0]       m_data_wr_q, m_data_wr_d;

   logic [NUM_REQ-1:0]      pick_grant;
   logic [IDX_W-1:0]        pick_idx;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx)
   );

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
   endfunction

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      grant_d       = grant_q;
      timer_d       = timer_q;
      done_d        = '0;
      err_d         = '0;
      timeout_d     = '0;
      m_ena_d       = m_ena_q;
      m_addr_d      = m_addr_q;
      m_rw_d        = m_rw_q;
      m_read_only_d = m_read_only_q;
      m_nbytes_d    = m_nbytes_q;
      m_data_wr_d   = m_data_wr_q;

      unique case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = pick_grant;
               owner_d = pick_idx;
               m_ena_d = 1'b1;
               timer_d = '0;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (pick_grant[i]) begin
                     m_addr_d      = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
                     m_rw_d        = req_rw[i];
                     m_read_only_d = req_read_only[i];
                     m_nbytes_d    = req_nbytes[i*NBYTES_W +: NBYTES_W];
                     m_data_wr_d   = req_data_wr[i*DATA_W +: DATA_W];
                  end
               end
               state_d = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (m_busy) begin
               state_d = RUN;
            end else if (timer_q == TO_LAST) begin
               // Advancing ptr on a timeout too keeps a dead requester from hogging the bus.
               m_ena_d   = 1'b0;
               done_d    = grant_q;
               err_d     = grant_q;
               timeout_d = grant_q;
               grant_d   = '0;
               timer_d   = '0;
               ptr_d     = next_idx(owner_q);
               state_d   = GAP;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         RUN: begin
            if ((m_byte_counter >= m_nbytes_q) || m_ack_error) begin
               m_ena_d = 1'b0;
               done_d  = grant_q;
               err_d   = m_ack_error ? grant_q : '0;
               grant_d = '0;
               timer_d = '0;
               ptr_d   = next_idx(owner_q);
               state_d = GAP;
            end
         end
         GAP: begin
            if ((timer_q >= GAP_LAST) && !m_busy) begin
               state_d = IDLE;
            end else if (timer_q < GAP_LAST) begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         owner_q       <= '0;
         grant_q       <= '0;
         timer_q       <= '0;
         done_q        <= '0;
         err_q         <= '0;
         timeout_q     <= '0;
         m_ena_q       <= 1'b0;
         m_addr_q      <= '0;
         m_rw_q        <= 1'b0;
         m_read_only_q <= 1'b0;
         m_nbytes_q    <= '0;
         m_data_wr_q   <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         grant_q       <= grant_d;
         timer_q       <= timer_d;
         done_q        <= done_d;
         err_q         <= err_d;
         timeout_q     <= timeout_d;
         m_ena_q       <= m_ena_d;
         m_addr_q      <= m_addr_d;
         m_rw_q        <= m_rw_d;
         m_read_only_q <= m_read_only_d;
         m_nbytes_q    <= m_nbytes_d;
         m_data_wr_q   <= m_data_wr_d;
      end
   end

   assign grant       = grant_q;
   assign done        = done_q;
   assign err         = err_q;
   assign timeout     = timeout_q;
   assign rd_data     = m_data_rd;
   assign rd_valid    = {NUM_REQ{m_fifo_write_ack}} & grant_q;
   assign m_ena       = m_ena_q;
   assign m_addr      = m_addr_q;
   assign m_rw        = m_rw_q;
   assign m_read_only = m_read_only_q;
   assign m_nbytes    = m_nbytes_q;
   assign m_data_wr   = m_data_wr_q;

endmodule

// File: doc/tlv_i2c_arbiter.md
Name: tlv_i2c_arbiter

Overview:
- Shares one i2c_master core between NUM_REQ requesters, e.g. several TLV493 sensor FSMs on a common SDA/SCL pair.
- Grants the bus round-robin at transaction granularity.
- Latches the winning request into the master's command registers, then drives ena.
- Watches busy, byte_counter and ack_error for completion; returns data and status to the granted requester only.

Parameters:
- NUM_REQ, 4, number of requesters (1..16).
- CLOCK_SPEED_HZ, 50_000_000, system clock frequency; used only for documentation and derived defaults.
- START_TIMEOUT, 1000, cycles allowed between ena rising and busy rising before abort.
- BUS_FREE_CYCLES, 125, minimum idle cycles between transactions (≈2.5 µs at 50 MHz).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  request per requester; hold high until done
- req_addr  in  7*NUM_REQ  I2C 7-bit address, slice i
- req_rw  in  NUM_REQ  1 = read, 0 = write
- req_read_only  in  NUM_REQ  read without register-pointer write
- req_nbytes  in  8*NUM_REQ  byte count, slice i
- req_data_wr  in  32*NUM_REQ  write payload, slice i
- grant  out  NUM_REQ  one-hot current owner
- done  out  NUM_REQ  1-cycle completion pulse to owner
- err  out  NUM_REQ  status, valid with done: ack_error or timeout
- timeout  out  NUM_REQ  valid with done: 1 = start timeout
- rd_data  out  32  master data_rd, broadcast
- rd_valid  out  NUM_REQ  fifo_write_ack gated by grant
- m_ena  out  1  to i2c_master ena
- m_addr  out  7  to master addr
- m_rw  out  1  to master rw
- m_read_only  out  1  to master read_only
- m_nbytes  out  8  to master number_of_bytes
- m_data_wr  out  32  to master data_wr
- m_busy  in  1  from master busy
- m_ack_error  in  1  from master ack_error
- m_byte_counter  in  8  from master byte_counter
- m_data_rd  in  32  from master data_rd
- m_fifo_write_ack  in  1  from master fifo_write_ack

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer 0; counters 0.
- States:
  - IDLE: if |req, select the first set bit at or after ptr (wrapping), register it.
    - grant set, m_* fields latched from the winner's slice, m_ena=1, timer cleared → WAIT_BUSY.
    - Latency from req to m_ena is 1 cycle.
  - WAIT_BUSY:
    - m_busy=1 → RUN.
    - Otherwise timer++. At timer==START_TIMEOUT-1: m_ena=0, done/err/timeout pulse to owner → GAP.
  - RUN:
    - Completion when m_byte_counter>=m_nbytes or m_ack_error=1.
    - On completion: m_ena=0, done pulse, err=m_ack_error, timeout=0, ptr=owner+1 mod NUM_REQ → GAP.
  - GAP:
    - grant cleared on entry.
    - Counts BUS_FREE_CYCLES and requires m_busy=0.
    - Both satisfied → IDLE.
- m_* fields stay stable from IDLE exit until GAP entry; requester inputs are ignored after latch.
- req dropped mid-transaction: transaction still completes and done still pulses.
- req held after done: the requester competes again in the next IDLE, behind the others (fairness).
- Simultaneous completion and ack_error: a single done, err=1.
- rd_valid[i] = m_fifo_write_ack & grant[i], combinational; rd_data = m_data_rd.
- m_nbytes=0 latched: completes in the first RUN cycle.
- Reset asserted mid-transaction: everything returns to reset values immediately. The master is reset separately by its own reset_n.
- NUM_REQ=1: the arbiter degenerates to a sequencer with gap and timeout.

Decomposition:
- Package tlv_i2c_arb_pkg:
  - state enum {IDLE, WAIT_BUSY, RUN, GAP}
  - I2C_ADDR_W=7, NBYTES_W=8, DATA_W=32
  - TLV_I2C_ADDR=7'h5e
- Sub-module rr_picker: combinational round-robin; inputs req vector and ptr; outputs one-hot grant and index.

Test Plan:
- Req0 only, addr 5e, read, nbytes 7; model raises busy 3 cycles after ena and counts to 7 → m_ena high from cycle 1, done[0] once, err=0, grant cleared, next grant ≥125 cycles later.
- Req0 and req2 asserted together, held → grant order 0,2,0,2; each done matches its grant; rd_valid only on the owner.
- Req1 write nbytes 4 data 32'h0143_A5C1; model asserts ack_error after byte 1 → m_data_wr=32'h0143A5C1 during RUN, done[1] with err[1]=1.
- Model never raises busy → done[3] at START_TIMEOUT cycles after ena, err[3]=1, timeout[3]=1, m_ena low.
- Reset pulsed during RUN with req held → all outputs 0 asynchronously; new transaction restarts from IDLE with ptr=0.
- All four requesters held 20 transactions → each granted exactly 5 times, no two grants overlap.
